// File: rtl/mult_mantisa_seq_pkg.sv
// Shared types and constants for the single-precision multiplier front end.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ZERO    = 2'd0,
    NORMAL  = 2'd1,
    SPECIAL = 2'd2
  } opclass_t;

  localparam int unsigned BIAS   = 127;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned PROD_W = 48;

  localparam logic [8:0]        EXP_SPECIAL  = 9'h1FF;
  localparam logic [PROD_W-1:0] SPECIAL_PROD = 48'h4000_0000_0000;

endpackage

// File: rtl/mult_mantisa_seq_if.sv
// Request/result bundle between the multiplier and its client.
interface mult_mantisa_seq_if;
  import fp_mul_pkg::*;

  // start is sampled only while busy is low; the request is taken on that edge.
  // done pulses for one cycle when Signo_mul/Exp_resul/Producto become valid;
  // they then hold until the next done.
  logic              start;
  logic [31:0]       A;
  logic [31:0]       B;
  logic              busy;
  logic              done;
  logic              Signo_mul;
  logic [8:0]        Exp_resul;
  logic [PROD_W-1:0] Producto;
  state_t            dbg_state;

  modport master (
    output start, A, B,
    input  busy, done, Signo_mul, Exp_resul, Producto, dbg_state
  );

  modport slave (
    input  start, A, B,
    output busy, done, Signo_mul, Exp_resul, Producto, dbg_state
  );

endinterface

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 single into sign, exponent and significand and classifies it.
module fp_unpack
  import fp_mul_pkg::*;
(
  input  logic [31:0]       op_i,
  output logic              sign_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic [MANT_W-1:0] mant_o,
  output opclass_t          cls_o
);

  always_comb begin
    sign_o = op_i[31];
    exp_o  = op_i[30:23];
    mant_o = '0;
    cls_o  = NORMAL;
    // Denormals are flushed: they get the zero class and a zero significand.
    if (op_i[30:23] == 8'h00) begin
      cls_o = ZERO;
    end else if (op_i[30:23] == 8'hFF) begin
      cls_o = SPECIAL;
    end else begin
      mant_o = {1'b1, op_i[FRAC_W-1:0]};
    end
  end

endmodule

// File: rtl/mult_mantisa_seq.sv
// Sequential shift-add significand multiplier with sign/exponent handling.
// Define MULT_RADIX4_EN to retire two multiplier bits per iteration.
module mult_mantisa_seq
  import fp_mul_pkg::*;
#(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned BIAS   = 127
)
(
  input  logic               clk,
  input  logic               rst_n,
  mult_mantisa_seq_if.slave  bus
);

`ifdef MULT_RADIX4_EN
  localparam int unsigned ITER = MANT_W / 2;
`else
  localparam int unsigned ITER = MANT_W;
`endif
  localparam int unsigned CNT_W = $clog2(MANT_W);
  localparam int unsigned P_W   = 2 * MANT_W;

  logic              a_sign, b_sign;
  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [MANT_W-1:0] a_mant, b_mant;
  opclass_t          a_cls, b_cls;

  fp_unpack u_unpack_a (.op_i(bus.A), .sign_o(a_sign), .exp_o(a_exp), .mant_o(a_mant), .cls_o(a_cls));
  fp_unpack u_unpack_b (.op_i(bus.B), .sign_o(b_sign), .exp_o(b_exp), .mant_o(b_mant), .cls_o(b_cls));

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MANT_W-1:0] mcand_q, mcand_d;
  logic [P_W-1:0]    prod_q, prod_d;
  logic [8:0]        expo_q, expo_d;
  logic              sign_q, sign_d;
  logic [P_W-1:0]    out_prod_q, out_prod_d;
  logic [8:0]        out_exp_q, out_exp_d;
  logic              out_sign_q, out_sign_d;

  logic [9:0]        exp_sum;
  logic              any_special, any_zero, underflow;
  logic [P_W-1:0]    step_prod;

  always_comb begin
    exp_sum     = {2'b00, a_exp} + {2'b00, b_exp};
    any_special = (a_cls == SPECIAL) || (b_cls == SPECIAL);
    any_zero    = (a_cls == ZERO) || (b_cls == ZERO);
    underflow   = (exp_sum <= 10'(BIAS));
  end

  // Product word: upper half accumulates, lower half holds the unconsumed multiplier.
`ifdef MULT_RADIX4_EN
  logic [MANT_W+1:0] m_ext, addend, step_sum;
  always_comb begin
    m_ext = {2'b00, mcand_q};
    case (prod_q[1:0])
      2'd1:    addend = m_ext;
      2'd2:    addend = m_ext << 1;
      2'd3:    addend = m_ext + (m_ext << 1);
      default: addend = '0;
    endcase
    step_sum  = {2'b00, prod_q[P_W-1:MANT_W]} + addend;
    step_prod = {step_sum, prod_q[MANT_W-1:2]};
  end
`else
  logic [MANT_W:0] step_sum;
  always_comb begin
    step_sum  = {1'b0, prod_q[P_W-1:MANT_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    step_prod = {step_sum, prod_q[MANT_W-1:1]};
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    expo_d     = expo_q;
    sign_d     = sign_q;
    out_prod_d = out_prod_q;
    out_exp_d  = out_exp_q;
    out_sign_d = out_sign_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d = a_sign ^ b_sign;
          if (any_special) begin
            out_prod_d = SPECIAL_PROD;
            out_exp_d  = EXP_SPECIAL;
            out_sign_d = a_sign ^ b_sign;
            state_d    = DONE;
          end else if (any_zero || underflow) begin
            out_prod_d = '0;
            out_exp_d  = '0;
            out_sign_d = a_sign ^ b_sign;
            state_d    = DONE;
          end else begin
            mcand_d = a_mant;
            prod_d  = {{MANT_W{1'b0}}, b_mant};
            expo_d  = 9'(exp_sum - 10'(BIAS));
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        prod_d = step_prod;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) begin
          cnt_d      = '0;
          out_prod_d = step_prod;
          out_exp_d  = expo_q;
          out_sign_d = sign_q;
          state_d    = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      prod_q     <= '0;
      expo_q     <= '0;
      sign_q     <= 1'b0;
      out_prod_q <= '0;
      out_exp_q  <= '0;
      out_sign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      expo_q     <= expo_d;
      sign_q     <= sign_d;
      out_prod_q <= out_prod_d;
      out_exp_q  <= out_exp_d;
      out_sign_q <= out_sign_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.Signo_mul = out_sign_q;
  assign bus.Exp_resul = out_exp_q;
  assign bus.Producto  = out_prod_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mult_mantisa_seq.sv
// Self-checking bench for mult_mantisa_seq (both radix modes via MULT_RADIX4_EN).
module tb_mult_mantisa_seq;
  import fp_mul_pkg::*;

`ifdef MULT_RADIX4_EN
  localparam int NORM_LAT = 13;
`else
  localparam int NORM_LAT = 25;
`endif

  logic clk;
  logic rst_n;
  mult_mantisa_seq_if bus ();

  mult_mantisa_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  logic [57:0] exp_q[$];
  int          lat_q[$];

  // Reference: {sign, exp[8:0], product[47:0]}
  function automatic logic [57:0] model(input logic [31:0] a, input logic [31:0] b);
    logic       s;
    logic [9:0] es;
    logic [47:0] ma, mb, p;
    s  = a[31] ^ b[31];
    es = {2'b00, a[30:23]} + {2'b00, b[30:23]};
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 9'h1FF, 48'h4000_0000_0000};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 9'd0, 48'd0};
    if (es <= 10'd127) return {s, 9'd0, 48'd0};
    ma = {24'd0, 1'b1, a[22:0]};
    mb = {24'd0, 1'b1, b[22:0]};
    p  = ma * mb;
    return {s, 9'(es - 10'd127), p};
  endfunction

  function automatic bit is_fast(input logic [31:0] a, input logic [31:0] b);
    logic [9:0] es;
    es = {2'b00, a[30:23]} + {2'b00, b[30:23]};
    return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) ||
           (a[30:23] == 8'h00) || (b[30:23] == 8'h00) || (es <= 10'd127);
  endfunction

  // Leaves the caller at #1 after the accepting edge (edge 1).
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    exp_q.push_back(model(a, b));
    lat_q.push_back(is_fast(a, b) ? 1 : NORM_LAT);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic collect(input int n0);
    int          n;
    int          lat;
    logic [57:0] e;
    n = n0;
    while (bus.done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    e   = exp_q.pop_front();
    lat = lat_q.pop_front();
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d edges, required 1 within %0d", bus.done, n, lat);
    end else begin
      if (n != lat) begin
        errors++;
        $display("FAIL latency: got %0d edges, required %0d", n, lat);
      end
      checks++;
      if (bus.Signo_mul !== e[57]) begin
        errors++;
        $display("FAIL sign: got %b, required %b", bus.Signo_mul, e[57]);
      end
      checks++;
      if (bus.Exp_resul !== e[56:48]) begin
        errors++;
        $display("FAIL exp: got %0d, required %0d", bus.Exp_resul, e[56:48]);
      end
      checks++;
      if (bus.Producto !== e[47:0]) begin
        errors++;
        $display("FAIL prod: got %h, required %h", bus.Producto, e[47:0]);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Producto !== e[47:0]) begin
        errors++;
        $display("FAIL pulse_hold: done=%b busy=%b prod=%h, required done=0 busy=0 prod=%h",
                 bus.done, bus.busy, bus.Producto, e[47:0]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = 32'h0;
    bus.B     = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b state=%0d, required 0 0 0", bus.busy, bus.done, bus.dbg_state);
    end
    checks++;
    if (bus.Signo_mul !== 1'b0 || bus.Exp_resul !== 9'd0 || bus.Producto !== 48'd0) begin
      errors++;
      $display("FAIL reset_data: sign=%b exp=%0d prod=%h, required all 0", bus.Signo_mul, bus.Exp_resul, bus.Producto);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_normal();
    issue(32'h3FC0_0000, 32'h3FC0_0000);
    checks++;
    if (bus.busy !== 1'b1 || bus.dbg_state !== CALC) begin
      errors++;
      $display("FAIL calc_busy: busy=%b state=%0d, required 1 %0d", bus.busy, bus.dbg_state, CALC);
    end
    collect(1);
    issue(32'hC040_0000, 32'h4080_0000);
    collect(1);
  endtask

  task automatic test_fast_path();
    issue(32'h0000_0000, 32'h4000_0000);
    collect(1);
    issue(32'h0080_0000, 32'h0080_0000);
    collect(1);
    issue(32'h8000_0001, 32'h3F80_0000);
    collect(1);
  endtask

  task automatic test_extremes();
    issue(32'h7F7F_FFFF, 32'h7F7F_FFFF);
    collect(1);
    issue(32'h7F80_0000, 32'h7F7F_FFFF);
    collect(1);
    issue(32'h3F80_0000, 32'hFFC0_0000);
    collect(1);
    issue(32'h3F80_0001, 32'h3F00_0000);
    collect(1);
  endtask

  task automatic test_start_ignored();
    issue(32'hC040_0000, 32'h4080_0000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    bus.start = 1'b1;
    bus.A     = 32'h7F80_0000;
    bus.B     = 32'h0000_0000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    collect(6);
  endtask

  task automatic test_reset_abort();
    issue(32'h4049_0FDB, 32'hC02D_F854);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Signo_mul !== 1'b0 ||
        bus.Exp_resul !== 9'd0 || bus.Producto !== 48'd0) begin
      errors++;
      $display("FAIL async_abort: busy=%b done=%b sign=%b exp=%0d prod=%h, required all 0",
               bus.busy, bus.done, bus.Signo_mul, bus.Exp_resul, bus.Producto);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h4049_0FDB, 32'hC02D_F854);
    collect(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      a[31]    = 1'($urandom_range(0, 1));
      b[31]    = 1'($urandom_range(0, 1));
      a[30:23] = (i % 4 == 3) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(60, 200));
      b[30:23] = 8'($urandom_range(60, 200));
      a[22:0]  = 23'($urandom_range(0, 32'h7F_FFFF));
      b[22:0]  = 23'($urandom_range(0, 32'h7F_FFFF));
      issue(a, b);
      collect(1);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_fast_path();
    test_extremes();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
